bcd_time_counters: RTL and testbench
====================================

BCD_TIME_COUNTERS -- requirements
Module: bcd_time_counters

Interface
REQ-001 SHALL have parameter HOUR_CARRY, default 0; when 1, hour advances on minute rollover 59->00 in addition to hour_en.
REQ-002 SHALL have port CP, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port min_en, input, 1 bit: minute-units count enable, level-sensitive, sampled each CP edge.
REQ-005 SHALL have port hour_en, input, 1 bit: hour count enable, level-sensitive, sampled each CP edge.
REQ-006 SHALL have port min_lo, output, 4 bits: minute units BCD digit, 0..9.
REQ-007 SHALL have port min_hi, output, 4 bits: minute tens BCD digit, 0..5.
REQ-008 SHALL have port hour_lo, output, 4 bits: hour units BCD digit, 0..9 (0..3 when hour_hi=2).
REQ-009 SHALL have port hour_hi, output, 4 bits: hour tens BCD digit, 0..2.
REQ-010 SHALL have port min_carry, output, 1 bit: combinational, high when min_en=1 and minutes = 59.

Function
REQ-011 SHALL implement three counters: mod-10 (min_lo), mod-6 (min_hi), mod-24 two-digit BCD (hour_hi:hour_lo).
REQ-012 Mod-10: when enabled, increments by 1 per CP edge; 9 wraps to 0; holds when disabled.
REQ-013 Mod-6: enabled only when min_en=1 and min_lo=9 (same edge as min_lo wrap); 5 wraps to 0; holds otherwise.
REQ-014 Mod-24: when enabled, counts 00..23 in BCD; hour_lo 9 -> 0 with hour_hi+1; 23 -> 00; holds when disabled.
REQ-015 Hour enable SHALL be hour_en OR (HOUR_CARRY=1 AND min_carry); simultaneous sources SHALL advance hour by exactly 1.
REQ-016 Latency: every output reflects an enabled increment one CP edge after the enable is sampled; no combinational path from enables to digit outputs.
REQ-017 Minute and hour counters SHALL be independent when HOUR_CARRY=0; min_en and hour_en both high advance both in the same edge.
REQ-018 Any out-of-range digit state (min_lo>9, min_hi>5, hour>23 or non-BCD) SHALL load 0 on the next enabled edge of that counter.
REQ-019 Outputs SHALL be driven directly from registers; digit outputs never glitch between edges.
REQ-020 Upper unused bits of each 4-bit digit output SHALL read 0 whenever the value is in range.

Reset
REQ-021 reset=0 SHALL immediately, without waiting for CP, force min_lo, min_hi, hour_lo, hour_hi to 0.
REQ-022 While reset=0 all counters SHALL hold 0 regardless of enables; min_carry SHALL read 0.
REQ-023 Reset release SHALL be synchronized internally (async assert, sync deassert); the first count may occur on the second CP edge after reset rises.
REQ-024 Reset asserted mid-operation (e.g. at 23:59) SHALL yield 00:00 with no partial carry applied.

Structure
REQ-025 Shared package SHALL hold constants: BCD digit width 4, MOD_MIN_LO=10, MOD_MIN_HI=6, HOURS_PER_DAY=24, and max-digit constants 9, 5, 2, 3.
REQ-026 One sub-module bcd_digit_counter (parameter MODULUS, ports CP, reset, EN, Cnt, wrap flag) SHALL be instantiated for min_lo and min_hi; the hour counter SHALL be a dedicated two-digit block in the top level.
REQ-027 The reset synchronizer SHALL be a single two-flop instance in the top level feeding all counters.

Verification
REQ-028 Reset: drive counts to 12:34, pull reset low between edges -> all digits 0 immediately; release, no enables -> stays 00:00.
REQ-029 Minute wrap: min_en=1 for 60 edges from 00 -> min_lo cycles 0..9, min_hi 0..5, returns to 00; min_carry high exactly at the 59 edge; hour unchanged (HOUR_CARRY=0).
REQ-030 Hour wrap: hour_en=1 for 24 edges from 00 -> sequence 00,01..09,10..19,20..23,00; hour_hi never exceeds 2, hour_lo never exceeds 3 when hour_hi=2.
REQ-031 Carry mode: HOUR_CARRY=1, start 23:58, min_en=1 two edges -> 23:59 then 00:00; with hour_en also high on the 59 edge -> hour advances once only.
REQ-032 Hold: enables low for 100 edges at 07:45 -> outputs remain 07:45; min_en pulsed one cycle -> 07:46.
REQ-033 Simultaneous: min_en=1 and hour_en=1 at 09:09 -> next edge 10:10.

Source files
------------

// File: rtl/bcd_time_counters_pkg.sv
// Shared constants and the BCD digit type for the hh:mm counter slice.
package bcd_time_counters_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam int MOD_MIN_LO    = 10;
  localparam int MOD_MIN_HI    = 6;
  localparam int HOURS_PER_DAY = 24;

  localparam bcd_t MAX_UNITS       = 4'd9;
  localparam bcd_t MAX_MIN_HI      = 4'd5;
  localparam bcd_t MAX_HOUR_HI     = 4'd2;
  localparam bcd_t MAX_HOUR_LO_TOP = 4'd3;

endpackage

// File: rtl/bcd_time_counters_if.sv
// Bundle of the counter's enables, BCD digits and minute carry.
interface bcd_time_counters_if import bcd_time_counters_pkg::*;;
  // No valid/ready: each enable is a level sampled on every rising CP edge,
  // and the digits are registered values that change only on that edge.
  logic min_en;
  logic hour_en;
  bcd_t min_lo;
  bcd_t min_hi;
  bcd_t hour_lo;
  bcd_t hour_hi;
  logic min_carry;

  modport master (
    output min_en, hour_en,
    input  min_lo, min_hi, hour_lo, hour_hi, min_carry
  );

  modport slave (
    input  min_en, hour_en,
    output min_lo, min_hi, hour_lo, hour_hi, min_carry
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counting 0..MODULUS-1; any state at or above the top value reloads 0.
module bcd_digit_counter
  import bcd_time_counters_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic CP,
  input  logic reset,
  input  logic EN,
  output bcd_t Cnt,
  output logic Wrap
);

  localparam bcd_t MAX_VAL = bcd_t'(MODULUS - 1);

  bcd_t r_cnt;

  // ">=" folds illegal codes into the normal wrap path.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (EN) begin
      if (r_cnt >= MAX_VAL) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 4'd1;
    end
  end

  assign Cnt  = r_cnt;
  assign Wrap = EN && (r_cnt == MAX_VAL);

endmodule

// File: rtl/bcd_time_counters.sv
// hh:mm BCD counter: minute units/tens digit counters plus a two-digit mod-24 hour block.
module bcd_time_counters
  import bcd_time_counters_pkg::*;
#(
  parameter bit HOUR_CARRY = 1'b0
) (
  input  logic CP,
  input  logic reset,
  input  logic min_en,
  input  logic hour_en,
  output bcd_t min_lo,
  output bcd_t min_hi,
  output bcd_t hour_lo,
  output bcd_t hour_hi,
  output logic min_carry
);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  logic       w_min_lo_wrap;
  logic       w_min_hi_wrap;
  logic       w_hour_en;
  logic       w_hour_bad;
  bcd_t       r_hour_lo;
  bcd_t       r_hour_hi;

  // Assert passes straight through the flops' async clear; release takes two edges.
  always_ff @(posedge CP or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  bcd_digit_counter #(.MODULUS(MOD_MIN_LO)) u_min_lo (
    .CP    (CP),
    .reset (w_rst_n),
    .EN    (min_en),
    .Cnt   (min_lo),
    .Wrap  (w_min_lo_wrap)
  );

  bcd_digit_counter #(.MODULUS(MOD_MIN_HI)) u_min_hi (
    .CP    (CP),
    .reset (w_rst_n),
    .EN    (w_min_lo_wrap),
    .Cnt   (min_hi),
    .Wrap  (w_min_hi_wrap)
  );

  // The tens wrap flag is exactly "min_en at 59".
  assign min_carry = w_min_hi_wrap;
  assign w_hour_en = hour_en || (HOUR_CARRY && min_carry);

  assign w_hour_bad = (r_hour_hi > MAX_HOUR_HI) || (r_hour_lo > MAX_UNITS) ||
                      ((r_hour_hi == MAX_HOUR_HI) && (r_hour_lo > MAX_HOUR_LO_TOP));

  always_ff @(posedge CP or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hour_lo <= '0;
      r_hour_hi <= '0;
    end else if (w_hour_en) begin
      if (w_hour_bad ||
          ((r_hour_hi == MAX_HOUR_HI) && (r_hour_lo == MAX_HOUR_LO_TOP))) begin
        r_hour_lo <= '0;
        r_hour_hi <= '0;
      end else if (r_hour_lo == MAX_UNITS) begin
        r_hour_lo <= '0;
        r_hour_hi <= r_hour_hi + 4'd1;
      end else begin
        r_hour_lo <= r_hour_lo + 4'd1;
      end
    end
  end

  assign hour_lo = r_hour_lo;
  assign hour_hi = r_hour_hi;

endmodule

// File: tb/tb_bcd_time_counters.sv
// Directed bench for bcd_time_counters: one instance per HOUR_CARRY setting.
module tb_bcd_time_counters;
  import bcd_time_counters_pkg::*;

  logic CP;
  logic reset;
  int   checks;
  int   failures;

  logic [15:0] exp_q[$];

  bcd_time_counters_if bus0 ();
  bcd_time_counters_if bus1 ();

  bcd_time_counters #(.HOUR_CARRY(1'b0)) dut0 (
    .CP        (CP),
    .reset     (reset),
    .min_en    (bus0.min_en),
    .hour_en   (bus0.hour_en),
    .min_lo    (bus0.min_lo),
    .min_hi    (bus0.min_hi),
    .hour_lo   (bus0.hour_lo),
    .hour_hi   (bus0.hour_hi),
    .min_carry (bus0.min_carry)
  );

  bcd_time_counters #(.HOUR_CARRY(1'b1)) dut1 (
    .CP        (CP),
    .reset     (reset),
    .min_en    (bus1.min_en),
    .hour_en   (bus1.hour_en),
    .min_lo    (bus1.min_lo),
    .min_hi    (bus1.min_hi),
    .hour_lo   (bus1.hour_lo),
    .hour_hi   (bus1.hour_hi),
    .min_carry (bus1.min_carry)
  );

  // ---------------- clock / reset ----------------
  initial CP = 1'b0;
  always #5 CP = ~CP;

  // ---------------- helpers ----------------
  function automatic logic [15:0] hm(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] time0();
    return {bus0.hour_hi, bus0.hour_lo, bus0.min_hi, bus0.min_lo};
  endfunction

  function automatic logic [15:0] time1();
    return {bus1.hour_hi, bus1.hour_lo, bus1.min_hi, bus1.min_lo};
  endfunction

  task automatic check_t(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_en(input int d, input logic me, input logic he);
    if (d == 0) begin
      bus0.min_en  = me;
      bus0.hour_en = he;
    end else begin
      bus1.min_en  = me;
      bus1.hour_en = he;
    end
  endtask

  task automatic tick();
    @(posedge CP);
    @(negedge CP);
  endtask

  task automatic run(input int d, input logic me, input logic he, input int n);
    set_en(d, me, he);
    repeat (n) tick();
    set_en(d, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        me;
    logic        he;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    set_en(0, 1'b0, 1'b0);
    set_en(1, 1'b0, 1'b0);

    vecs[0] = '{1'b1, 1'b0, hm(0, 1)};
    vecs[1] = '{1'b1, 1'b0, hm(0, 2)};
    vecs[2] = '{1'b0, 1'b1, hm(1, 2)};
    vecs[3] = '{1'b1, 1'b1, hm(2, 3)};
    vecs[4] = '{1'b0, 1'b0, hm(2, 3)};
    vecs[5] = '{1'b0, 1'b1, hm(3, 3)};
    vecs[6] = '{1'b1, 1'b0, hm(3, 4)};
    vecs[7] = '{1'b1, 1'b1, hm(4, 5)};

    // Reset state, held through enables, then release with enables low.
    set_en(0, 1'b1, 1'b1);
    repeat (3) tick();
    check_t("reset_hold_dut0", time0(), hm(0, 0));
    check_b("reset_carry_dut0", bus0.min_carry, 1'b0);
    set_en(0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (4) tick();
    check_t("post_reset_dut0", time0(), hm(0, 0));
    check_t("post_reset_dut1", time1(), hm(0, 0));

    // Table-driven single-edge vectors on the independent-counter instance.
    foreach (vecs[i]) begin
      set_en(0, vecs[i].me, vecs[i].he);
      exp_q.push_back(vecs[i].exp);
      tick();
      check_t($sformatf("vec%0d", i), time0(), exp_q.pop_front());
    end
    set_en(0, 1'b0, 1'b0);

    // Async reset from 12:34, asserted between edges.
    run(0, 1'b0, 1'b1, 8);
    run(0, 1'b1, 1'b0, 29);
    check_t("reach_12_34", time0(), hm(12, 34));
    #2 reset = 1'b0;
    #1 check_t("async_reset_now", time0(), hm(0, 0));
    set_en(0, 1'b1, 1'b1);
    repeat (3) tick();
    check_t("reset_low_enables", time0(), hm(0, 0));
    check_b("reset_low_carry", bus0.min_carry, 1'b0);
    set_en(0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (5) tick();
    check_t("release_idle", time0(), hm(0, 0));

    // Minute wrap over 60 edges; hour untouched without HOUR_CARRY.
    for (int i = 0; i < 60; i++) begin
      set_en(0, 1'b1, 1'b0);
      check_b($sformatf("min_carry_at_%0d", i), bus0.min_carry, (i == 59));
      tick();
      check_t($sformatf("min_wrap_%0d", i), time0(), hm(0, (i + 1) % 60));
    end
    set_en(0, 1'b0, 1'b0);

    // Hour wrap over 24 edges.
    for (int i = 0; i < 24; i++) begin
      set_en(0, 1'b0, 1'b1);
      tick();
      check_t($sformatf("hour_wrap_%0d", i), time0(), hm((i + 1) % 24, 0));
    end
    set_en(0, 1'b0, 1'b0);

    // Hold at 07:45 for 100 idle edges, then a one-cycle minute pulse.
    run(0, 1'b0, 1'b1, 7);
    run(0, 1'b1, 1'b0, 45);
    check_t("reach_07_45", time0(), hm(7, 45));
    repeat (50) tick();
    check_t("hold_mid", time0(), hm(7, 45));
    repeat (50) tick();
    check_t("hold_end", time0(), hm(7, 45));
    run(0, 1'b1, 1'b0, 1);
    check_t("pulse_07_46", time0(), hm(7, 46));

    // Both enables at 09:09.
    run(0, 1'b1, 1'b0, 23);
    check_t("min_wrap_no_carry", time0(), hm(7, 9));
    run(0, 1'b0, 1'b1, 2);
    check_t("reach_09_09", time0(), hm(9, 9));
    run(0, 1'b1, 1'b1, 1);
    check_t("simul_10_10", time0(), hm(10, 10));
    check_t("dut1_idle", time1(), hm(0, 0));

    // HOUR_CARRY instance: 23:58 -> 23:59 -> 00:00.
    run(1, 1'b0, 1'b1, 23);
    run(1, 1'b1, 1'b0, 58);
    check_t("carry_reach_23_58", time1(), hm(23, 58));
    set_en(1, 1'b1, 1'b0);
    check_b("carry_low_at_58", bus1.min_carry, 1'b0);
    tick();
    check_t("carry_23_59", time1(), hm(23, 59));
    check_b("carry_high_at_59", bus1.min_carry, 1'b1);
    tick();
    check_t("carry_00_00", time1(), hm(0, 0));
    set_en(1, 1'b0, 1'b0);
    check_b("carry_needs_min_en", bus1.min_carry, 1'b0);

    // Both hour sources on the 59 edge advance the hour once.
    run(1, 1'b0, 1'b1, 10);
    run(1, 1'b1, 1'b0, 59);
    check_t("carry_reach_10_59", time1(), hm(10, 59));
    run(1, 1'b1, 1'b1, 1);
    check_t("carry_double_src", time1(), hm(11, 0));

    // Mid-operation reset at 23:59 leaves no partial carry.
    run(1, 1'b0, 1'b1, 12);
    run(1, 1'b1, 1'b0, 59);
    check_t("carry_reach_23_59", time1(), hm(23, 59));
    set_en(1, 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1 check_t("reset_at_23_59", time1(), hm(0, 0));
    tick();
    set_en(1, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (4) tick();
    check_t("reset_23_59_release", time1(), hm(0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
